// File: rtl/ring_pkg.sv
// Shared types and phase encodings for consumers of the 4-phase one-hot ring counter.
`timescale 1ns/1ps
package ring_pkg;

    typedef enum logic [0:0] {
        SEEK     = 1'b0,
        ASSEMBLE = 1'b1
    } state_e;

    localparam logic [3:0] PH0 = 4'b1000;
    localparam logic [3:0] PH1 = 4'b0100;
    localparam logic [3:0] PH2 = 4'b0010;
    localparam logic [3:0] PH3 = 4'b0001;

endpackage

// File: rtl/onehot4_check.sv
// Combinational one-hot validator: legal flag plus binary phase index (1000 -> 0 ... 0001 -> 3).
`timescale 1ns/1ps
module onehot4_check
    import ring_pkg::*;
(
    input  logic [3:0] vec,
    output logic       legal,
    output logic [1:0] idx
);

    // Decode the vector; anything that is not exactly one-hot is illegal
    always_comb begin
        legal = 1'b0;
        idx   = 2'd0;
        case (vec)
            PH0: begin legal = 1'b1; idx = 2'd0; end
            PH1: begin legal = 1'b1; idx = 2'd1; end
            PH2: begin legal = 1'b1; idx = 2'd2; end
            PH3: begin legal = 1'b1; idx = 2'd3; end
            default: begin legal = 1'b0; idx = 2'd0; end
        endcase
    end

endmodule

// File: rtl/ring_frame_assembler.sv
// Turns the ring counter's phase rotation plus a serial bit per phase into 4-bit frames,
// with sequence-error, lock and frame-count reporting.
`timescale 1ns/1ps
module ring_frame_assembler
    import ring_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       phase,
    input  logic             din,
    input  logic             err_clr,
    output logic [3:0]       frame,
    output logic             frame_valid,
    output logic [1:0]       phase_idx,
    output logic             locked,
    output logic             phase_err,
    output logic [CNT_W-1:0] frame_cnt
);

    logic             ph_legal_s;
    logic [1:0]       ph_idx_s;
    logic             err_s;

    state_e           state_q, state_d;
    logic [1:0]       exp_q, exp_d;
    logic [3:0]       shift_q, shift_d;
    logic [3:0]       frame_q, frame_d;
    logic             frame_valid_q, frame_valid_d;
    logic [1:0]       phase_idx_q, phase_idx_d;
    logic             locked_q, locked_d;
    logic             phase_err_q, phase_err_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    onehot4_check u_check (
        .vec   (phase),
        .legal (ph_legal_s),
        .idx   (ph_idx_s)
    );

    // Next-state: resync on 1000, advance on the expected phase, flag anything else
    always_comb begin
        state_d       = state_q;
        exp_d         = exp_q;
        shift_d       = shift_q;
        frame_d       = frame_q;
        frame_valid_d = 1'b0;
        phase_idx_d   = phase_idx_q;
        locked_d      = locked_q;
        frame_cnt_d   = frame_cnt_q;
        err_s         = 1'b0;
        if (err_clr) begin
            phase_err_d = 1'b0;
        end else begin
            phase_err_d = phase_err_q;
        end

        if (!ph_legal_s) begin
            err_s = 1'b1;
        end else begin
            phase_idx_d = ph_idx_s;
            if (ph_idx_s == 2'd0) begin
                shift_d = {din, 3'b000};
                exp_d   = 2'd1;
                state_d = ASSEMBLE;
            end else if (state_q == ASSEMBLE) begin
                if (ph_idx_s == exp_q) begin
                    if (ph_idx_s == 2'd3) begin
                        frame_d       = {shift_q[3:1], din};
                        frame_valid_d = 1'b1;
                        frame_cnt_d   = frame_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        locked_d      = 1'b1;
                        shift_d       = 4'b0000;
                        exp_d         = 2'd0;
                        state_d       = SEEK;
                    end else begin
                        shift_d[2'd3 - ph_idx_s] = din;
                        exp_d = exp_q + 2'd1;
                    end
                end else begin
                    err_s = 1'b1;
                end
            end else begin
                // Legal non-1000 phase while seeking: counter has not come round yet
                state_d = SEEK;
            end
        end

        // An error outranks err_clr and drops the partial frame
        if (err_s) begin
            phase_err_d = 1'b1;
            locked_d    = 1'b0;
            shift_d     = 4'b0000;
            exp_d       = 2'd0;
            state_d     = SEEK;
        end else begin
            locked_d    = locked_d;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SEEK;
            exp_q         <= 2'd0;
            shift_q       <= 4'b0000;
            frame_q       <= 4'b0000;
            frame_valid_q <= 1'b0;
            phase_idx_q   <= 2'd0;
            locked_q      <= 1'b0;
            phase_err_q   <= 1'b0;
            frame_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            exp_q         <= exp_d;
            shift_q       <= shift_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            phase_idx_q   <= phase_idx_d;
            locked_q      <= locked_d;
            phase_err_q   <= phase_err_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign frame       = frame_q;
    assign frame_valid = frame_valid_q;
    assign phase_idx   = phase_idx_q;
    assign locked      = locked_q;
    assign phase_err   = phase_err_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_ring_frame_assembler.sv
// Scoreboard bench for ring_frame_assembler: expected frames are queued as rotations are driven
// and matched when frame_valid pulses.
`timescale 1ns/1ps
module tb_ring_frame_assembler;
    import ring_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] phase;
    logic       din;
    logic       err_clr;
    logic [3:0] frame;
    logic       frame_valid;
    logic [1:0] phase_idx;
    logic       locked;
    logic       phase_err;
    logic [7:0] frame_cnt;

    int         tests;
    int         fails;
    int         pulses;
    logic [3:0] sb_q[$];
    logic [3:0] mon_exp;
    logic [7:0] exp_cnt;

    ring_frame_assembler #(.CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .phase       (phase),
        .din         (din),
        .err_clr     (err_clr),
        .frame       (frame),
        .frame_valid (frame_valid),
        .phase_idx   (phase_idx),
        .locked      (locked),
        .phase_err   (phase_err),
        .frame_cnt   (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every frame_valid pulse must match the oldest queued frame
    always @(negedge clk) begin
        if (rst_n === 1'b1 && frame_valid === 1'b1) begin
            pulses++;
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL frame_unexpected got=%b expected=none", frame);
            end else begin
                mon_exp = sb_q.pop_front();
                if (frame !== mon_exp) begin
                    fails++;
                    $display("FAIL frame_data got=%b expected=%b", frame, mon_exp);
                end
            end
        end
    end

    task automatic drive(input logic [3:0] ph, input logic d);
        phase = ph;
        din   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic rotate(input logic [3:0] n);
        drive(PH0, n[3]);
        drive(PH1, n[2]);
        drive(PH2, n[1]);
        sb_q.push_back(n);
        exp_cnt = exp_cnt + 8'd1;
        drive(PH3, n[0]);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({frame, frame_valid, phase_idx, locked, phase_err} !== 9'b0 || frame_cnt !== 8'd0) begin
            fails++;
            $display("FAIL reset_values got=%b/%b/%b/%b/%b/%0d expected=all zero",
                     frame, frame_valid, phase_idx, locked, phase_err, frame_cnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_nominal();
        rotate(4'b1011);
        tests++;
        if (frame_valid !== 1'b1 || frame !== 4'b1011) begin
            fails++;
            $display("FAIL nominal_frame got=%b valid=%b expected=1011 valid=1", frame, frame_valid);
        end
        tests++;
        if (locked !== 1'b1 || frame_cnt !== 8'd1 || phase_idx !== 2'd3) begin
            fails++;
            $display("FAIL nominal_status got locked=%b cnt=%0d idx=%0d expected locked=1 cnt=1 idx=3",
                     locked, frame_cnt, phase_idx);
        end
        drive(PH1, 1'b0);
        tests++;
        if (frame_valid !== 1'b0 || phase_err !== 1'b0 || phase_idx !== 2'd1) begin
            fails++;
            $display("FAIL nominal_pulse_end got valid=%b err=%b idx=%0d expected valid=0 err=0 idx=1",
                     frame_valid, phase_err, phase_idx);
        end
    endtask

    task automatic test_preset_resync();
        int p0;
        p0 = pulses;
        repeat (5) drive(PH0, 1'b1);
        tests++;
        if (phase_err !== 1'b0 || frame_valid !== 1'b0 || phase_idx !== 2'd0) begin
            fails++;
            $display("FAIL preset_hold got err=%b valid=%b idx=%0d expected err=0 valid=0 idx=0",
                     phase_err, frame_valid, phase_idx);
        end
        rotate(4'b0110);
        drive(PH1, 1'b0);
        tests++;
        if (pulses - p0 != 1 || phase_err !== 1'b0 || frame_cnt !== exp_cnt) begin
            fails++;
            $display("FAIL preset_resync got pulses=%0d err=%b cnt=%0d expected pulses=1 err=0 cnt=%0d",
                     pulses - p0, phase_err, frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_skip_error();
        drive(PH0, 1'b1);
        drive(PH2, 1'b1);
        tests++;
        if (phase_err !== 1'b1 || locked !== 1'b0) begin
            fails++;
            $display("FAIL skip_flags got err=%b locked=%b expected err=1 locked=0", phase_err, locked);
        end
        tests++;
        if (frame !== 4'b0110 || frame_cnt !== exp_cnt || frame_valid !== 1'b0) begin
            fails++;
            $display("FAIL skip_hold got frame=%b cnt=%0d valid=%b expected frame=0110 cnt=%0d valid=0",
                     frame, frame_cnt, frame_valid, exp_cnt);
        end
        rotate(4'b1100);
        tests++;
        if (frame_valid !== 1'b1 || phase_err !== 1'b1 || locked !== 1'b1 || frame_cnt !== exp_cnt) begin
            fails++;
            $display("FAIL skip_recover got valid=%b err=%b locked=%b cnt=%0d expected valid=1 err=1 locked=1 cnt=%0d",
                     frame_valid, phase_err, locked, frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_illegal();
        drive(4'b0000, 1'b0);
        tests++;
        if (phase_err !== 1'b1 || phase_idx !== 2'd3 || locked !== 1'b0) begin
            fails++;
            $display("FAIL illegal_zero got err=%b idx=%0d locked=%b expected err=1 idx=3 locked=0",
                     phase_err, phase_idx, locked);
        end
        drive(4'b0110, 1'b1);
        tests++;
        if (phase_err !== 1'b1 || phase_idx !== 2'd3) begin
            fails++;
            $display("FAIL illegal_multi got err=%b idx=%0d expected err=1 idx=3", phase_err, phase_idx);
        end
        err_clr = 1'b1;
        drive(4'b0000, 1'b0);
        tests++;
        if (phase_err !== 1'b1) begin
            fails++;
            $display("FAIL illegal_clr_race got err=%b expected err=1", phase_err);
        end
        drive(PH3, 1'b0);
        err_clr = 1'b0;
        tests++;
        if (phase_err !== 1'b0 || phase_idx !== 2'd3 || frame_valid !== 1'b0) begin
            fails++;
            $display("FAIL illegal_clr got err=%b idx=%0d valid=%b expected err=0 idx=3 valid=0",
                     phase_err, phase_idx, frame_valid);
        end
    endtask

    task automatic test_wrap();
        int  p0;
        logic seen_wrap;
        p0 = pulses;
        seen_wrap = 1'b0;
        for (int i = 0; i < 256; i++) begin
            rotate(4'($urandom_range(0, 15)));
            tests++;
            if (frame_cnt !== exp_cnt) begin
                fails++;
                $display("FAIL wrap_cnt got=%0d expected=%0d", frame_cnt, exp_cnt);
            end
            if (exp_cnt == 8'd0 && frame_cnt === 8'd0) seen_wrap = 1'b1;
        end
        drive(PH1, 1'b0);
        tests++;
        if (pulses - p0 != 256 || seen_wrap !== 1'b1 || locked !== 1'b1) begin
            fails++;
            $display("FAIL wrap_pulses got pulses=%0d wrapped=%b locked=%b expected pulses=256 wrapped=1 locked=1",
                     pulses - p0, seen_wrap, locked);
        end
    endtask

    task automatic test_reset_mid();
        drive(PH0, 1'b1);
        drive(PH1, 1'b1);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({frame, frame_valid, phase_idx, locked, phase_err} !== 9'b0 || frame_cnt !== 8'd0) begin
            fails++;
            $display("FAIL reset_mid_values got=%b/%b/%b/%b/%b/%0d expected=all zero",
                     frame, frame_valid, phase_idx, locked, phase_err, frame_cnt);
        end
        exp_cnt = 8'd0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive(PH2, 1'b1);
        drive(PH3, 1'b1);
        tests++;
        if (frame_valid !== 1'b0 || phase_err !== 1'b0 || frame_cnt !== 8'd0 || phase_idx !== 2'd3) begin
            fails++;
            $display("FAIL reset_mid_partial got valid=%b err=%b cnt=%0d idx=%0d expected valid=0 err=0 cnt=0 idx=3",
                     frame_valid, phase_err, frame_cnt, phase_idx);
        end
        rotate(4'b0101);
        tests++;
        if (frame_valid !== 1'b1 || frame !== 4'b0101 || frame_cnt !== 8'd1 || locked !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_frame got valid=%b frame=%b cnt=%0d locked=%b expected valid=1 frame=0101 cnt=1 locked=1",
                     frame_valid, frame, frame_cnt, locked);
        end
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        pulses  = 0;
        exp_cnt = 8'd0;
        rst_n   = 1'b0;
        phase   = 4'b0000;
        din     = 1'b0;
        err_clr = 1'b0;

        test_reset();
        test_nominal();
        test_preset_resync();
        test_skip_error();
        test_illegal();
        test_wrap();
        test_reset_mid();
        drive(PH1, 1'b0);

        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got=%0d pending expected=0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ring_frame_assembler.md
# ring_frame_assembler

Downstream consumer of the 4-phase one-hot ring counter. Each clock it checks the counter's phase vector against the legal rotation 1000 → 0100 → 0010 → 0001 → 1000 and samples one serial data bit per phase. A complete rotation becomes a 4-bit frame with a one-cycle valid strobe. The block also reports sequence errors, lock status and a running frame count, so later stages see parallel nibbles instead of raw phases.

## Interface
Parameters:
- CNT_W, 8, width of the wrapping frame counter.

Ports:
- clk  in  1  rising-edge clock, shared with the ring counter.
- rst_n  in  1  reset, asynchronous, active-low.
- phase  in  4  one-hot phase vector straight from the ring counter outputs.
- din  in  1  serial data, sampled on every rising edge together with phase.
- err_clr  in  1  synchronous clear for phase_err.
- frame  out  4  last completed frame; bit3 = sample taken at phase 1000, bit0 = sample taken at phase 0001.
- frame_valid  out  1  one-cycle pulse; frame is updated on the same edge.
- phase_idx  out  2  registered binary index of the last legal phase (1000→0, 0100→1, 0010→2, 0001→3).
- locked  out  1  high after at least one complete, error-free rotation.
- phase_err  out  1  sticky flag for an illegal or out-of-sequence phase.
- frame_cnt  out  CNT_W  number of completed frames, modulo 2^CNT_W.

## Operation
- States: SEEK and ASSEMBLE.
  - SEEK waits for phase 1000.
  - ASSEMBLE tracks the next expected phase in an internal 2-bit register.
- Decisions are made on each rising edge, using sampled phase and din:
  - **Legal phase:** exactly one bit set.
  - **phase == 1000 (any state):** clear the partial frame, store din into shift[3], set expected to 0100, go to ASSEMBLE. This is a silent resync with no error.
    - It covers the ring counter being held in preset (start low), where 1000 repeats every cycle.
  - **ASSEMBLE, phase equals expected (0100 or 0010):** store din into the matching shift bit and advance expected.
  - **ASSEMBLE, phase equals expected 0001:**
    - frame ← {shift[3:1], din}
    - frame_valid ← 1
    - frame_cnt ← frame_cnt + 1, wrapping from 2^CNT_W−1 to 0
    - locked ← 1
    - go to SEEK, expecting 1000 next.
  - **SEEK, phase legal but not 1000:** ignore it and stay in SEEK. No error, because the counter may not yet have rotated round to 1000.
  - **Illegal vector (0000 or multi-hot), or any legal phase other than expected or 1000 while in ASSEMBLE:**
    - phase_err ← 1, locked ← 0
    - discard the partial frame, go to SEEK
    - frame and frame_cnt hold their values.
- phase_idx updates on every legal phase and holds its value on illegal vectors.
- err_clr clears phase_err on the next edge. If err_clr and a new error arrive in the same cycle, the error wins and phase_err stays 1.
- locked clears only on an error or on reset. A 1000 resync does not clear it.

## Timing
- All outputs are registered; no combinational path from input to output.
- Latency: frame and frame_valid update on the same edge that samples phase 0001. frame_valid is high for exactly one cycle and drops on the next edge unless another frame completes.
- Maximum throughput is one frame every 4 cycles.
- Reset values: state = SEEK; frame = 0000, frame_valid = 0, phase_idx = 00, locked = 0, phase_err = 0, frame_cnt = 0; internal shift register = 0.
- Reset asserted mid-frame clears everything immediately. After release the block resumes in SEEK, and no partial frame is ever emitted.
- frame_cnt wraps silently; there is no overflow flag.

## Structure
- Shared package ring_pkg holds:
  - the state enum {SEEK, ASSEMBLE}
  - phase constants PH0 = 4'b1000, PH1 = 4'b0100, PH2 = 4'b0010, PH3 = 4'b0001.
- One sub-module, onehot4_check: combinational legal flag plus 2-bit index from a 4-bit vector. It is reusable by other ring-counter consumers.
- The rest is a single sequential process plus next-state logic.

## Test plan
- **Nominal stream:** reset, release, drive phase 1000/0100/0010/0001 with din 1,0,1,1.
  - frame = 1011 with frame_valid high one cycle, on the edge sampling 0001.
  - locked = 1, frame_cnt = 1.
- **Preset hold then resync:** phase held at 1000 for 5 cycles, then a normal rotation with din 0,1,1,0.
  - No error.
  - Exactly one frame, 0110.
- **Skip error:** phase 1000, 0010, with locked = 1 beforehand.
  - phase_err = 1 and locked = 0 after the 0010 edge.
  - frame and frame_cnt unchanged.
  - The next full rotation produces a frame while phase_err stays 1.
- **Illegal vectors:** phase 0000, then 0110.
  - phase_err = 1 and phase_idx holds its previous value.
  - err_clr pulsed together with a further 0000 leaves phase_err at 1.
  - err_clr alone clears it.
- **Counter wrap:** with CNT_W = 8, run 256 clean rotations. frame_cnt goes 255 → 0 and frame_valid pulses 256 times.
- **Reset mid-frame:** drop rst_n after the 0100 edge.
  - All outputs go to their reset values immediately.
  - After release, a rotation starting at 0010 produces no frame and no error; the next full rotation produces a frame.
